// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and Z/N/C/V flags.
// Optional iterative shift-add multiplier on opcode 10 when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SHL   = 4'd3;
  localparam logic [3:0] OP_SHR   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_ONES  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_ASR   = 4'd11;
  localparam logic [3:0] OP_XOR   = 4'd12;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

  // Returns {result, carry, overflow}; an in-range shift amount always fits in SHW bits.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [WIDTH-1:0] op_a,
                                                input logic [WIDTH-1:0] op_b,
                                                input logic [3:0]       op);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             vf;
    logic             big;
    wide = '0;
    res  = '0;
    cf   = 1'b0;
    vf   = 1'b0;
    big  = (op_b >= WIDTH'(WIDTH));
    case (op)
      OP_ADD: begin
        wide = {1'b0, op_a} + {1'b0, op_b};
        res  = wide[WIDTH-1:0];
        cf   = wide[WIDTH];
        vf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        wide = {1'b0, op_a} - {1'b0, op_b};
        res  = wide[WIDTH-1:0];
        cf   = ~wide[WIDTH];
        vf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SHL: begin
        if (big) res = '0;
        else     res = op_a << op_b[SHW-1:0];
      end
      OP_SHR: begin
        if (big) res = '0;
        else     res = op_a >> op_b[SHW-1:0];
      end
      OP_ASR: begin
        if (big) res = {WIDTH{op_a[WIDTH-1]}};
        else     res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
      end
      OP_AND:         res = op_a & op_b;
      OP_OR:          res = op_a | op_b;
      OP_PASSB:       res = op_b;
      OP_PASSA:       res = op_a;
      OP_ONES:        res = '1;
      OP_XOR:         res = op_a ^ op_b;
      OP_NOP, OP_MUL: res = '0;
      default:        res = '0;
    endcase
    return {res, cf, vf};
  endfunction

  state_t           state_r;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic [WIDTH-1:0] mul_res_s;
  logic             mul_v_s;

  assign in_ready = (state_r == IDLE) || ((state_r == HOLD) && out_ready);
  assign accept_s = in_valid && in_ready;

  // Single-cycle datapath evaluated on the live operands.
  always_comb begin
    {alu_res_s, alu_c_s, alu_v_s} = alu_eval(a, b, sel);
  end

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [SHW-1:0]     cnt_r;

  // Next partial product and completion detect for the shift-add loop.
  always_comb begin
    acc_next_s = acc_r + (mplier_r[0] ? mcand_r : '0);
    is_mul_s   = (sel == OP_MUL);
    mul_done_s = (state_r == MUL) && (cnt_r == SHW'(WIDTH - 1));
    mul_res_s  = acc_next_s[WIDTH-1:0];
    mul_v_s    = |acc_next_s[2*WIDTH-1:WIDTH];
  end

  // Multiplier operand/accumulator registers: one partial product per edge in MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
    end else if (accept_s && is_mul_s) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      acc_r    <= '0;
      cnt_r    <= '0;
    end else if (state_r == MUL) begin
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      acc_r    <= acc_next_s;
      cnt_r    <= cnt_r + 1'b1;
    end else begin
      cnt_r    <= cnt_r;
    end
  end
`else
  // Without the multiplier, opcode 10 takes the single-cycle NOP path.
  always_comb begin
    is_mul_s   = 1'b0;
    mul_done_s = 1'b0;
    mul_res_s  = '0;
    mul_v_s    = 1'b0;
  end
`endif

  // Control FSM and registered result/flags; a HOLD drain and a new accept can share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
    end else if (accept_s) begin
      if (is_mul_s) begin
`ifdef ALU_PIPE_MUL_EN
        state_r <= MUL;
`endif
        out_valid <= 1'b0;
      end else begin
        state_r   <= HOLD;
        out_valid <= 1'b1;
        result    <= alu_res_s;
        z         <= (alu_res_s == '0);
        n         <= alu_res_s[WIDTH-1];
        c         <= alu_c_s;
        v         <= alu_v_s;
      end
    end else if (mul_done_s) begin
      state_r   <= HOLD;
      out_valid <= 1'b1;
      result    <= mul_res_s;
      z         <= (mul_res_s == '0);
      n         <= mul_res_s[WIDTH-1];
      c         <= 1'b0;
      v         <= mul_v_s;
    end else if ((state_r == HOLD) && out_ready) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_r;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8); MUL expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       z;
  logic       n;
  logic       c;
  logic       v;

  typedef logic [11:0] exp_t;  // {result, z, n, c, v}

  exp_t exp_q[$];
  int   pop_cyc[$];
  exp_t sb_e;
  int   cyc = 0;
  int   sb_checks = 0;
  int   sb_errors = 0;
  int   dr_checks = 0;
  int   dr_errors = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .n(n), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output transfer pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      sb_checks++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        sb_errors++;
        $display("FAIL sb_unexpected got result=%h znvc=%b%b%b%b", result, z, n, c, v);
      end else begin
        sb_e = exp_q.pop_front();
        if ({result, z, n, c, v} !== sb_e)
          begin
            sb_errors++;
            $display("FAIL sb_result got result=%h zncv=%b%b%b%b exp result=%h zncv=%b",
                     result, z, n, c, v, sb_e[11:4], sb_e[3:0]);
          end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    dr_checks++;
    if (got !== expv) begin
      dr_errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] op,
                      input logic [7:0] er, input logic [3:0] ezncv, output int waited);
    a = ta; b = tb_v; sel = op; in_valid = 1'b1;
    exp_q.push_back({er, ezncv});
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("accept_bound", (waited < 50), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_lat(output int lat, output logic busy_ok);
    lat = 1; busy_ok = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   lat;
    int   p0;
    logic busy_ok;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00; sel = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_valid, result, z, n, c, v}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // ADD overflow into sign bit, one-cycle latency.
    send(8'h7F, 8'h05, 4'd1, 8'h84, 4'b0101, w);
    wait_lat(lat, busy_ok);
    chk("add_latency", lat, 1);
    @(posedge clk); #1;

    // Back-to-back SUBs must stream at full rate.
    p0 = pop_cyc.size();
    send(8'hCC, 8'hCC, 4'd2, 8'h00, 4'b1010, w);
    send(8'd30, 8'd100, 4'd2, 8'hBA, 4'b0100, w);
    chk("sub2_no_stall", w, 0);
    send(8'd57, 8'd51, 4'd2, 8'h06, 4'b0010, w);
    chk("sub3_no_stall", w, 0);
    for (int i = 0; i < 10 && pop_cyc.size() < p0 + 3; i++) @(negedge clk);
    @(posedge clk); #1;
    chk("sub_pops", (pop_cyc.size() >= p0 + 3), 1);
    chk("sub_consecutive", (pop_cyc.size() >= p0 + 3) ? (pop_cyc[p0+2] - pop_cyc[p0]) : 99, 2);

    // Shifts, including out-of-range amounts.
    send(8'hFF, 8'd2, 4'd3, 8'hFC, 4'b0100, w);
    send(8'hFF, 8'd2, 4'd4, 8'h3F, 4'b0000, w);
    send(8'h80, 8'd2, 4'd11, 8'hE0, 4'b0100, w);
    send(8'hFF, 8'd9, 4'd3, 8'h00, 4'b1000, w);
    send(8'hFF, 8'd9, 4'd4, 8'h00, 4'b1000, w);
    send(8'h80, 8'd9, 4'd11, 8'hFF, 4'b0100, w);
    send(8'h40, 8'd8, 4'd11, 8'h00, 4'b1000, w);

    // Remaining single-cycle ops and carry boundary.
    send(8'hFF, 8'h01, 4'd1, 8'h00, 4'b1010, w);
    send(8'h80, 8'h80, 4'd1, 8'h00, 4'b1011, w);
    send(8'hAA, 8'h55, 4'd12, 8'hFF, 4'b0100, w);
    send(8'hC3, 8'h3C, 4'd5, 8'h00, 4'b1000, w);
    send(8'h00, 8'h00, 4'd9, 8'hFF, 4'b0100, w);
    send(8'h12, 8'h34, 4'd7, 8'h34, 4'b0000, w);
    send(8'h12, 8'h34, 4'd8, 8'h12, 4'b0000, w);
    send(8'h12, 8'h34, 4'd0, 8'h00, 4'b1000, w);
    send(8'h12, 8'h34, 4'd14, 8'h00, 4'b1000, w);
    send(8'h80, 8'h01, 4'd2, 8'h7F, 4'b0011, w);

    // Multiply.
`ifdef ALU_PIPE_MUL_EN
    send(8'd13, 8'd11, 4'd10, 8'h8F, 4'b0100, w);
    wait_lat(lat, busy_ok);
    chk("mul_latency", lat, 8);
    chk("mul_busy_in_ready_low", busy_ok, 1);
    @(posedge clk); #1;
    send(8'hFF, 8'h02, 4'd10, 8'hFE, 4'b0101, w);
    wait_lat(lat, busy_ok);
    chk("mul2_latency", lat, 8);
    @(posedge clk); #1;
`else
    send(8'd13, 8'd11, 4'd10, 8'h00, 4'b1000, w);
    wait_lat(lat, busy_ok);
    chk("mul_nop_latency", lat, 1);
    @(posedge clk); #1;
    send(8'hFF, 8'h02, 4'd10, 8'h00, 4'b1000, w);
    wait_lat(lat, busy_ok);
    chk("mul2_nop_latency", lat, 1);
    @(posedge clk); #1;
`endif

    // Backpressure: result held while out_ready is low, then same-edge drain and accept.
    out_ready = 1'b0;
    send(8'h10, 8'h20, 4'd1, 8'h30, 4'b0000, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_stable", {out_valid, in_ready, result, z, n, c, v}, {1'b1, 1'b0, 8'h30, 4'b0000});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h0F, 8'hF0, 4'd6, 8'hFF, 4'b0100, w);
    chk("accept_on_release", w, 0);
    wait_lat(lat, busy_ok);
    chk("or_latency", lat, 1);
    @(posedge clk); #1;

    // Reset three edges after accepting opcode 10 with the output stalled.
    out_ready = 1'b0;
    send(8'd13, 8'd11, 4'd10, 8'h00, 4'b0000, w);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_op", {out_valid, result, z, n, c, v}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midreset", in_ready, 1);
    @(posedge clk); #1;
    send(8'hF0, 8'h3C, 4'd5, 8'h30, 4'b0000, w);
    wait_lat(lat, busy_ok);
    chk("and_latency", lat, 1);
    @(posedge clk); #1;

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_transfers_seen", (sb_checks >= 20), 1);
    $display("CHECKS %0d ERRORS %0d", sb_checks + dr_checks, sb_errors + dr_errors);
    $finish;
  end

endmodule
